lif_tm_core: RTL and testbench
==============================

# lif_tm_core

Time-multiplexed leaky integrate-and-fire core: one shared update datapath serves `N_NEURONS` neurons whose membrane state, refractory counters and input currents live in internal register files. A round-robin pointer updates one neuron per enabled cycle; a full pass over all neurons is one sweep, i.e. one neuron timestep. The core sits between the current sources (inputs, LFSR, weight muxes) and the spike/state output muxes of the top level. It replaces discrete per-neuron instances, and adds leak, threshold and refractory control.

## Interface
- `N_NEURONS`, 8, number of neurons (≥2); index width `IW = $clog2(N_NEURONS)`
- `WIDTH`, 8, membrane/current width
- `REF_W`, 3, refractory counter width
- `clk` input 1: single clock
- `rst_n` input 1: reset, asynchronous, active-low
- `en` input 1: advance the scheduler; low freezes all state
- `cur_wr_en` input 1: write strobe for the current buffer
- `cur_wr_idx` input IW: neuron index to write
- `cur_wr_data` input WIDTH: input current for that neuron
- `threshold` input WIDTH: firing threshold, live
- `leak_shift` input 3: leak = v >> leak_shift; 0 = no leak
- `refrac` input REF_W: refractory sweeps loaded after a spike
- `mon_idx` input IW: neuron to monitor
- `mon_state` output WIDTH: registered membrane of `mon_idx`
- `spike_valid` output 1: a spike occurred on the update of the previous cycle
- `spike_idx` output IW: index of that neuron
- `spike_vec` output N_NEURONS: spikes of the last completed sweep
- `sweep_done` output 1: one-cycle pulse after the last neuron's update

## Operation
- Pointer `ptr` starts at 0. On each cycle with `en`=1, neuron `ptr` is updated and `ptr` increments, wrapping from N_NEURONS-1 to 0. With `en`=0, nothing changes except current writes and `mon_state`.
- Update for neuron k, with v=v[k], r=ref[k], c=cur[k], all read at the start of the cycle:
  - If r≠0: v←0, r←r-1, no spike, c ignored.
  - Else: vl = v − (v>>leak_shift) when leak_shift≠0, else vl = v. sum = vl + c in WIDTH+1 bits, saturated to 2^WIDTH−1.
  - If sum ≥ threshold: spike, v←0, r←refrac. Otherwise v←sum.
  - `threshold`=0 makes every non-refractory update spike.
- Current buffer entries persist until rewritten; they are never cleared by an update.
- Write hazard: a write to the index being updated in the same cycle does not affect that update. The new value is used from the next sweep.
- A sweep accumulator records spikes per index. On the update of index N_NEURONS-1:
  - `spike_vec` ← accumulator, including that update's spike.
  - The accumulator clears.
  - `sweep_done` pulses on the following cycle.
- `mon_state` ← v[mon_idx], registered. It reflects stored state after the edge.

## Timing
- Reset (async assert): v, ref, cur, ptr, accumulator = 0. `spike_valid`, `spike_idx`, `spike_vec`, `sweep_done`, `mon_state` = 0.
- Update latency is 1 cycle. State write, `spike_valid`/`spike_idx` and accumulator all register on the edge that ends the update cycle.
- `spike_valid` is high for exactly one cycle per spike. There is no backpressure; the consumer must sample every cycle.
- `spike_vec` and `sweep_done` change together, 1 cycle after the last update edge. With `en` held high, `sweep_done` repeats every N_NEURONS cycles.
- `en` dropped mid-sweep: `ptr` and accumulator hold; the sweep resumes where it stopped. `spike_valid` and `sweep_done` are 0 while `en`=0.
- Reset mid-sweep discards the partial sweep. The first update after release is neuron 0.
- `threshold`, `leak_shift` and `refrac` are sampled in each update cycle. A change mid-sweep applies to the remaining neurons.

## Test plan
All scenarios use N_NEURONS=4, WIDTH=8, REF_W=3.
- Reset: assert `rst_n`=0 mid-run → all outputs 0 immediately. After release, with `en`=1 and cur=0, there are no spikes, and `sweep_done` pulses every 4 cycles.
- Integration: leak_shift=0, threshold=100, cur[0]=30, others 0 → v[0] = 30, 60, 90 over sweeps 1-3. Spike in sweep 4 with `spike_idx`=0, then v[0]=0 and `spike_vec`=4'b0001 for that sweep only.
- Leak: leak_shift=1, threshold=255, cur[2]=10 → `mon_state` with `mon_idx`=2 reads 10, 15, 18, 19, 20, 20 over successive sweeps, with no spikes.
- Refractory: threshold=50, refrac=2, cur[1]=60 → neuron 1 spikes in sweeps 1, 4, 7. v[1]=0 in the sweeps between.
- Saturation and hazard:
  - threshold=255, cur[3]=200 → sweep 1 v=200; sweep 2 sum saturates at 255 and spikes.
  - Writing cur[3]=0 in the cycle neuron 3 updates still uses 200 for that update.
- Enable gating: drop `en` for 5 cycles after neuron 1 updates → no outputs change. On resume, neuron 2 updates next and the sweep completes normally.

Source files
------------

// File: rtl/lif_tm_core.sv
// Time-multiplexed leaky integrate-and-fire core.
// One shared datapath updates one neuron per enabled cycle, round robin.
module lif_tm_core #(
  parameter int N_NEURONS = 8,
  parameter int WIDTH     = 8,
  parameter int REF_W     = 3,
  parameter int IW        = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 cur_wr_en,
  input  logic [IW-1:0]        cur_wr_idx,
  input  logic [WIDTH-1:0]     cur_wr_data,
  input  logic [WIDTH-1:0]     threshold,
  input  logic [2:0]           leak_shift,
  input  logic [REF_W-1:0]     refrac,
  input  logic [IW-1:0]        mon_idx,
  output logic [WIDTH-1:0]     mon_state,
  output logic                 spike_valid,
  output logic [IW-1:0]        spike_idx,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 sweep_done
);

  logic [WIDTH-1:0]     v_q   [N_NEURONS];
  logic [REF_W-1:0]     rf_q  [N_NEURONS];
  logic [WIDTH-1:0]     cur_q [N_NEURONS];
  logic [IW-1:0]        ptr;
  logic [N_NEURONS-1:0] acc_q;

  logic [WIDTH-1:0]     vk, ck, vl, sat, v_nx;
  logic [REF_W-1:0]     rk, r_nx;
  logic [WIDTH:0]       sum;
  logic                 refr, fire, last;
  logic [N_NEURONS-1:0] acc_nx;

  always_comb begin
    vk   = v_q[ptr];
    rk   = rf_q[ptr];
    ck   = cur_q[ptr];
    vl   = (leak_shift != 3'd0) ? vk - (vk >> leak_shift) : vk;
    sum  = {1'b0, vl} + {1'b0, ck};
    sat  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    refr = (rk != '0);
    fire = !refr && (sat >= threshold);
    v_nx = (refr || fire) ? '0 : sat;
    r_nx = refr ? rk - 1'b1 : (fire ? refrac : '0);
    last = (ptr == IW'(N_NEURONS - 1));
    acc_nx      = acc_q;
    acc_nx[ptr] = acc_q[ptr] | fire;
  end

  // Current buffer is written independently of the scheduler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) cur_q[i] <= '0;
    end else if (cur_wr_en) begin
      cur_q[cur_wr_idx] <= cur_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]  <= '0;
        rf_q[i] <= '0;
      end
      ptr         <= '0;
      acc_q       <= '0;
      spike_valid <= 1'b0;
      spike_idx   <= '0;
      spike_vec   <= '0;
      sweep_done  <= 1'b0;
    end else begin
      spike_valid <= en && fire;
      sweep_done  <= en && last;
      if (en) begin
        v_q[ptr]  <= v_nx;
        rf_q[ptr] <= r_nx;
        spike_idx <= ptr;
        ptr       <= last ? '0 : ptr + 1'b1;
        if (last) begin
          spike_vec <= acc_nx;
          acc_q     <= '0;
        end else begin
          acc_q <= acc_nx;
        end
      end
    end
  end

  // Forward the fresh value so mon_state matches stored state after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mon_state <= '0;
    else if (en && ptr == mon_idx) mon_state <= v_nx;
    else mon_state <= v_q[mon_idx];
  end

endmodule

// File: tb/tb_lif_tm_core.sv
// Scoreboard bench for lif_tm_core with N_NEURONS=4.
// Stimulus pushes expected sweeps/spikes; monitors pop on outputs.
module tb_lif_tm_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cur_wr_en = 1'b0;
  logic [1:0] cur_wr_idx = '0;
  logic [7:0] cur_wr_data = '0;
  logic [7:0] threshold = '0;
  logic [2:0] leak_shift = '0;
  logic [2:0] refrac = '0;
  logic [1:0] mon_idx = '0;
  logic [7:0] mon_state;
  logic       spike_valid;
  logic [1:0] spike_idx;
  logic [3:0] spike_vec;
  logic       sweep_done;

  lif_tm_core #(.N_NEURONS(4), .WIDTH(8), .REF_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cur_wr_en(cur_wr_en), .cur_wr_idx(cur_wr_idx),
    .cur_wr_data(cur_wr_data), .threshold(threshold),
    .leak_shift(leak_shift), .refrac(refrac),
    .mon_idx(mon_idx), .mon_state(mon_state),
    .spike_valid(spike_valid), .spike_idx(spike_idx),
    .spike_vec(spike_vec), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vec;
    logic [7:0] mon;
  } sweep_t;

  sweep_t sq[$];
  int     spk_q[$];
  int     n_tests = 0;
  int     n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && spike_valid) begin
      if (spk_q.size() == 0) chk("unexpected_spike", spike_idx, -1);
      else chk("spike_idx", spike_idx, spk_q.pop_front());
    end
    if (rst_n && sweep_done) begin
      if (sq.size() == 0) begin
        chk("unexpected_sweep", spike_vec, -1);
      end else begin
        sweep_t e;
        e = sq.pop_front();
        chk("spike_vec", spike_vec, e.vec);
        chk("mon_state", mon_state, e.mon);
      end
    end
  end

  task automatic exp_sweep(input logic [3:0] vec, input logic [7:0] mon);
    sweep_t e;
    e.vec = vec;
    e.mon = mon;
    sq.push_back(e);
  endtask

  task automatic wr_cur(input int idx, input int val);
    cur_wr_en   = 1'b1;
    cur_wr_idx  = 2'(idx);
    cur_wr_data = 8'(val);
    @(posedge clk);
    #1 cur_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    en = 1'b0;
    cur_wr_en = 1'b0;
    #1;
    chk("rst_mon", mon_state, 0);
    chk("rst_valid", spike_valid, 0);
    chk("rst_idx", spike_idx, 0);
    chk("rst_vec", spike_vec, 0);
    chk("rst_done", sweep_done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run(input int cycles);
    en = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 en = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    chk("sweeps_left", sq.size(), 0);
    chk("spikes_left", spk_q.size(), 0);
  endtask

  logic [7:0] hold_mon;
  logic [3:0] hold_vec;

  initial begin
    #2 rst_n = 1'b1;

    // Integration
    do_reset();
    threshold = 8'd100; leak_shift = 3'd0; refrac = 3'd0; mon_idx = 2'd0;
    wr_cur(0, 30);
    exp_sweep(4'b0000, 30);
    exp_sweep(4'b0000, 60);
    exp_sweep(4'b0000, 90);
    exp_sweep(4'b0001, 0);
    spk_q.push_back(0);
    exp_sweep(4'b0000, 30);
    run(20);
    drain();

    // Leak
    do_reset();
    threshold = 8'd255; leak_shift = 3'd1; refrac = 3'd0; mon_idx = 2'd2;
    wr_cur(2, 10);
    exp_sweep(4'b0000, 10);
    exp_sweep(4'b0000, 15);
    exp_sweep(4'b0000, 18);
    exp_sweep(4'b0000, 19);
    exp_sweep(4'b0000, 20);
    exp_sweep(4'b0000, 20);
    run(24);
    drain();

    // Refractory
    do_reset();
    threshold = 8'd50; leak_shift = 3'd0; refrac = 3'd2; mon_idx = 2'd1;
    wr_cur(1, 60);
    for (int s = 1; s <= 7; s++) begin
      if (s == 1 || s == 4 || s == 7) begin
        exp_sweep(4'b0010, 0);
        spk_q.push_back(1);
      end else begin
        exp_sweep(4'b0000, 0);
      end
    end
    run(28);
    drain();

    // Saturation with same-cycle write hazard on neuron 3
    do_reset();
    threshold = 8'd255; leak_shift = 3'd0; refrac = 3'd0; mon_idx = 2'd3;
    wr_cur(3, 200);
    exp_sweep(4'b0000, 200);
    exp_sweep(4'b1000, 0);
    spk_q.push_back(3);
    en = 1'b1;
    repeat (7) @(posedge clk);
    #1 cur_wr_en = 1'b1;
    cur_wr_idx = 2'd3;
    cur_wr_data = 8'd0;
    @(posedge clk);
    #1 cur_wr_en = 1'b0;
    en = 1'b0;
    drain();
    chk("sat_vec_hold", spike_vec, 4'b1000);

    // Mid-run reset, then idle sweeps with zero current
    run(2);
    do_reset();
    exp_sweep(4'b0000, 0);
    exp_sweep(4'b0000, 0);
    exp_sweep(4'b0000, 0);
    run(12);
    drain();

    // Enable gating after neuron 1 of sweep 2
    do_reset();
    threshold = 8'd100; leak_shift = 3'd0; refrac = 3'd0; mon_idx = 2'd0;
    wr_cur(0, 30);
    wr_cur(2, 60);
    exp_sweep(4'b0000, 30);
    exp_sweep(4'b0100, 60);
    spk_q.push_back(2);
    run(6);
    hold_mon = mon_state;
    hold_vec = spike_vec;
    chk("gate_mon_pre", hold_mon, 60);
    repeat (5) begin
      @(negedge clk);
      chk("gate_mon", mon_state, hold_mon);
      chk("gate_vec", spike_vec, hold_vec);
      chk("gate_valid", spike_valid, 0);
      chk("gate_done", sweep_done, 0);
    end
    @(posedge clk);
    #1;
    run(2);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
